pkt_stream_gen: RTL

//   Parametrised packet stream generator: on start, emits packets of pack_length beats over a per-beat valid/ready handshake.

---
 rtl/pkt_stream_gen_pkg.sv | 21 ++
 rtl/pkt_stream_gen_if.sv | 38 +++
 rtl/pkt_stream_gen_pattern.sv | 57 +++++
 rtl/pkt_stream_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pkt_stream_gen_pkg.sv
// pkt_gen_pkg: shared mode and FSM state encodings for the packet stream generator.
// Revision: 1.0
`default_nettype none

package pkt_gen_pkg;

   localparam logic [1:0] MODE_INCR  = 2'd0;
   localparam logic [1:0] MODE_CONST = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_WALK  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pkt_stream_gen_if.sv
// pkt_stream_gen_if: control inputs, status outputs and valid/ready stream of the generator.
// Revision: 1.0
`default_nettype none

interface pkt_stream_gen_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int GAP_W  = 4,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              stop;
   logic [1:0]        mode;
   logic              continuous;
   logic [LEN_W-1:0]  pack_length;
   logic [GAP_W-1:0]  gap_cycles;
   logic [DATA_W-1:0] seed;
   logic              ready;
   logic              valid;
   logic [DATA_W-1:0] data;
   logic              last;
   logic              busy;
   logic              len_err;
   logic [CNT_W-1:0]  pkt_cnt;

   // master is the generator side; slave is the controller plus stream sink
   modport master (
      input  start, stop, mode, continuous, pack_length, gap_cycles, seed, ready,
      output valid, data, last, busy, len_err, pkt_cnt
   );

   modport slave (
      output start, stop, mode, continuous, pack_length, gap_cycles, seed, ready,
      input  valid, data, last, busy, len_err, pkt_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pkt_stream_gen_pattern.sv
// pkt_gen_pattern: payload pattern register; reloads from seed on load, advances one step per beat.
// Revision: 1.0
`default_nettype none

module pkt_gen_pattern
   import pkt_gen_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] LFSR_TAP = DATA_W'(8'hB8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [1:0]        mode_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic [DATA_W-1:0] value_o
);

   logic [DATA_W-1:0] value_q;
   logic [DATA_W-1:0] value_d;
   logic [DATA_W-1:0] seed_nz_d;

   // LFSR and walking-one both lock up on an all-zero register
   assign seed_nz_d = (seed_i == '0) ? DATA_W'(1) : seed_i;

   always_comb begin
      value_d = value_q;
      if (load_i) begin
         case (mode_i)
            MODE_LFSR, MODE_WALK: value_d = seed_nz_d;
            default:              value_d = seed_i;
         endcase
      end else if (step_i) begin
         case (mode_i)
            MODE_INCR:  value_d = value_q + DATA_W'(1);
            MODE_CONST: value_d = value_q;
            MODE_LFSR:  value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_TAP : '0);
            MODE_WALK:  value_d = {value_q[DATA_W-2:0], value_q[DATA_W-1]};
            default:    value_d = value_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/pkt_stream_gen.sv
// pkt_stream_gen: packet stream generator top; control FSM, beat/gap counters and packet counter.
// Revision: 1.0
`default_nettype none

module pkt_stream_gen
   import pkt_gen_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                LEN_W    = 8,
   parameter int                GAP_W    = 4,
   parameter int                CNT_W    = 16,
   parameter logic [DATA_W-1:0] LFSR_TAP = DATA_W'(8'hB8)
) (
   input  logic               clk,
   input  logic               rst,
   pkt_stream_gen_if.master   bus
);

   state_t            state_q;
   logic [1:0]        mode_q;
   logic              cont_q;
   logic [LEN_W-1:0]  len_q;
   logic [GAP_W-1:0]  gap_q;
   logic [DATA_W-1:0] seed_q;
   logic [LEN_W-1:0]  beat_q;
   logic [GAP_W-1:0]  gap_cnt_q;
   logic              valid_q;
   logic              last_q;
   logic              busy_q;
   logic              len_err_q;
   logic [CNT_W-1:0]  pkt_cnt_q;

   logic              xfer_d;
   logic              load_d;
   logic [LEN_W-1:0]  beat_inc_d;
   logic [DATA_W-1:0] value_d;

   assign xfer_d     = valid_q && bus.ready;
   assign load_d     = (state_q == ST_LOAD);
   assign beat_inc_d = beat_q + LEN_W'(1);

   pkt_gen_pattern #(
      .DATA_W   (DATA_W),
      .LFSR_TAP (LFSR_TAP)
   ) u_pattern (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_d),
      .step_i  (xfer_d),
      .mode_i  (mode_q),
      .seed_i  (seed_q),
      .value_o (value_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_INCR;
         cont_q    <= 1'b0;
         len_q     <= '0;
         gap_q     <= '0;
         seed_q    <= '0;
         beat_q    <= '0;
         gap_cnt_q <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         len_err_q <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         len_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.pack_length == '0) begin
                     len_err_q <= 1'b1;
                  end else begin
                     mode_q  <= bus.mode;
                     cont_q  <= bus.continuous;
                     len_q   <= bus.pack_length;
                     gap_q   <= bus.gap_cycles;
                     seed_q  <= bus.seed;
                     busy_q  <= 1'b1;
                     state_q <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               beat_q  <= '0;
               valid_q <= 1'b1;
               last_q  <= (len_q == LEN_W'(1));
               state_q <= ST_SEND;
            end
            ST_SEND: begin
               if (xfer_d) begin
                  if (last_q) begin
                     pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                     valid_q   <= 1'b0;
                     last_q    <= 1'b0;
                     if (cont_q && !bus.stop) begin
                        if (gap_q != '0) begin
                           gap_cnt_q <= gap_q - GAP_W'(1);
                           state_q   <= ST_GAP;
                        end else begin
                           state_q   <= ST_LOAD;
                        end
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     beat_q <= beat_inc_d;
                     last_q <= (beat_inc_d == len_q - LEN_W'(1));
                  end
               end
            end
            ST_GAP: begin
               if (bus.stop) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (gap_cnt_q == '0) begin
                  state_q <= ST_LOAD;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.valid   = valid_q;
   assign bus.data    = value_d;
   assign bus.last    = last_q;
   assign bus.busy    = busy_q;
   assign bus.len_err = len_err_q;
   assign bus.pkt_cnt = pkt_cnt_q;

endmodule

`default_nettype wire
